// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// reset constants, the register bundle type and the byte-lane merge helper.
package clint_pkg;

  localparam logic [15:0] clint_msip      = 16'h0000;
  localparam logic [15:0] clint_mtimecmp  = 16'h4000;
  localparam logic [15:0] clint_mtimecmph = 16'h4004;
  localparam logic [15:0] clint_mtime     = 16'hBFF8;
  localparam logic [15:0] clint_mtimeh    = 16'hBFFC;

  localparam logic [63:0] init_mtimecmp = '1;

  typedef struct packed {
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
  } clint_reg_type;

  localparam clint_reg_type init_clint_reg = '{
    mtime:    '0,
    mtimecmp: init_mtimecmp,
    msip:     1'b0
  };

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_rtc.sv
// mtime prescaler: counts 0..clk_divider_rtc-1 and pulses tick on the terminal count.
module clint_rtc #(
  parameter logic [31:0] clk_divider_rtc = 32'd50
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [31:0] count;

  assign tick = (count == clk_divider_rtc - 32'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: memory-mapped mtime/mtimecmp/msip with a one-cycle
// registered bus response and registered timer/software interrupt outputs.
module clint
  import clint_pkg::*;
#(
  parameter logic [31:0] clk_divider_rtc = 32'd50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clint_valid,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        timer_irpt,
  output logic        soft_irpt
);

  clint_reg_type r;
  clint_reg_type rin;

  logic        tick;
  logic        accept;
  logic        wr;
  logic [15:0] offset;
  logic [31:0] rdata_next;
  logic        unused_addr;

  clint_rtc #(
    .clk_divider_rtc(clk_divider_rtc)
  ) u_rtc (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign offset      = clint_addr[15:0];
  assign unused_addr = ^clint_addr[31:16];
  assign accept      = clint_valid & ~clint_ready;
  assign wr          = accept & (|clint_wstrb);

  always_comb begin
    rdata_next = '0;
    case (offset)
      clint_msip:      rdata_next = {31'b0, r.msip};
      clint_mtimecmp:  rdata_next = r.mtimecmp[31:0];
      clint_mtimecmph: rdata_next = r.mtimecmp[63:32];
      clint_mtime:     rdata_next = r.mtime[31:0];
      clint_mtimeh:    rdata_next = r.mtime[63:32];
      default:         rdata_next = '0;
    endcase
  end

  // Bus writes to mtime overlay the already-incremented value, so a write
  // coinciding with a tick keeps the increment in its unwritten bytes.
  always_comb begin
    rin       = r;
    rin.mtime = r.mtime + {63'b0, tick};
    if (wr) begin
      case (offset)
        clint_msip:      if (clint_wstrb[0]) rin.msip = clint_wdata[0];
        clint_mtimecmp:  rin.mtimecmp[31:0]  = byte_merge(r.mtimecmp[31:0], clint_wdata, clint_wstrb);
        clint_mtimecmph: rin.mtimecmp[63:32] = byte_merge(r.mtimecmp[63:32], clint_wdata, clint_wstrb);
        clint_mtime:     rin.mtime[31:0]     = byte_merge(rin.mtime[31:0], clint_wdata, clint_wstrb);
        clint_mtimeh:    rin.mtime[63:32]    = byte_merge(rin.mtime[63:32], clint_wdata, clint_wstrb);
        default:         ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r           <= init_clint_reg;
      clint_ready <= 1'b0;
      clint_rdata <= '0;
      timer_irpt  <= 1'b0;
      soft_irpt   <= 1'b0;
    end else begin
      r           <= rin;
      clint_ready <= accept;
      clint_rdata <= accept ? rdata_next : '0;
      timer_irpt  <= (r.mtime >= r.mtimecmp);
      soft_irpt   <= r.msip;
    end
  end

endmodule

// File: tb/tb_clint.sv
// Randomised self-checking bench for clint: two instances (divider 4 and 1)
// share one bus and are compared each cycle against a behavioural model.
module tb_clint;

  localparam int unsigned DIV0 = 4;
  localparam int unsigned DIV1 = 1;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        ti    [2];
  logic        si    [2];

  clint #(.clk_divider_rtc(32'd4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .clint_valid (valid),
    .clint_addr  (addr),
    .clint_wdata (wdata),
    .clint_wstrb (wstrb),
    .clint_rdata (rdata[0]),
    .clint_ready (ready[0]),
    .timer_irpt  (ti[0]),
    .soft_irpt   (si[0])
  );

  clint #(.clk_divider_rtc(32'd1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .clint_valid (valid),
    .clint_addr  (addr),
    .clint_wdata (wdata),
    .clint_wstrb (wstrb),
    .clint_rdata (rdata[1]),
    .clint_ready (ready[1]),
    .timer_irpt  (ti[1]),
    .soft_irpt   (si[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural model state
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_ready;
  logic [31:0] m_rdata [2];
  logic        m_timer [2];
  logic        m_soft;
  int unsigned m_edges;
  logic [31:0] last_rd [2];

  function automatic int unsigned div_of(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  function automatic logic [31:0] merge32(input logic [31:0] old_val, input logic [31:0] d,
                                          input logic [3:0] strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = d[8*b +: 8];
    return res;
  endfunction

  function automatic logic [31:0] model_read(input int i, input logic [15:0] off);
    case (off)
      16'h0000: return {31'b0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mtime[i][31:0];
      16'hBFFC: return m_mtime[i][63:32];
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mtime[i] = 64'h0;
      m_rdata[i] = 32'h0;
      m_timer[i] = 1'b0;
    end
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip  = 1'b0;
    m_ready = 1'b0;
    m_soft  = 1'b0;
    m_edges = 0;
  endtask

  // Advance the model across one clock edge, then compare all outputs.
  task automatic step();
    logic        acc;
    logic [15:0] off;
    logic [63:0] nt  [2];
    logic [31:0] rv  [2];
    logic        t_n [2];
    logic        s_n;
    m_edges++;
    off = addr[15:0];
    acc = valid && !m_ready;
    for (int i = 0; i < 2; i++) begin
      rv[i]  = model_read(i, off);
      t_n[i] = (m_mtime[i] >= m_cmp);
      nt[i]  = m_mtime[i] + (((m_edges % div_of(i)) == 0) ? 64'd1 : 64'd0);
    end
    s_n = m_msip;
    if (acc && wstrb != 4'b0) begin
      case (off)
        16'h0000: if (wstrb[0]) m_msip = wdata[0];
        16'h4000: m_cmp[31:0]  = merge32(m_cmp[31:0], wdata, wstrb);
        16'h4004: m_cmp[63:32] = merge32(m_cmp[63:32], wdata, wstrb);
        16'hBFF8: for (int i = 0; i < 2; i++) nt[i][31:0]  = merge32(nt[i][31:0], wdata, wstrb);
        16'hBFFC: for (int i = 0; i < 2; i++) nt[i][63:32] = merge32(nt[i][63:32], wdata, wstrb);
        default: ;
      endcase
    end
    for (int i = 0; i < 2; i++) begin
      m_mtime[i] = nt[i];
      m_rdata[i] = acc ? rv[i] : 32'h0;
      m_timer[i] = t_n[i];
    end
    m_ready = acc;
    m_soft  = s_n;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ready%0d", i), ready[i], m_ready);
      check($sformatf("timer%0d", i), ti[i], m_timer[i]);
      check($sformatf("soft%0d", i), si[i], m_soft);
      if (m_ready) check($sformatf("rdata%0d", i), rdata[i], m_rdata[i]);
    end
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    wstrb = 4'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic access(input logic [15:0] off, input logic [31:0] d, input logic [3:0] strb);
    valid = 1'b1;
    addr  = {16'($urandom()), off};
    wdata = d;
    wstrb = strb;
    step();
    last_rd[0] = rdata[0];
    last_rd[1] = rdata[1];
    valid = 1'b0;
    wstrb = 4'b0;
    step();
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_ready"}, ready[i], 1'b0);
      check({tag, "_rdata"}, rdata[i], 32'h0);
      check({tag, "_timer"}, ti[i], 1'b0);
      check({tag, "_soft"}, si[i], 1'b0);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    check_cleared("rst");
    model_reset();
    valid = 1'b0;
    wstrb = 4'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [15:0] pick_off(input int unsigned s);
    case (s)
      0:       return 16'h0000;
      1:       return 16'h4000;
      2:       return 16'h4004;
      3:       return 16'hBFF8;
      4:       return 16'hBFFC;
      5:       return 16'h1234;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned pulses;
    logic [15:0] off;
    n_checks = 0;
    n_pass   = 0;
    rst   = 1'b1;
    valid = 1'b0;
    addr  = '0;
    wdata = '0;
    wstrb = '0;
    #2;
    apply_reset();

    // Free-running count and a read of mtime lo
    idle(40);
    access(16'hBFF8, 32'h0, 4'b0);
    check("mtime40", last_rd[0], 32'd10);
    check("timer_idle", ti[0], 1'b0);

    // Partial write onto the reset value of mtimecmp lo
    access(16'h4000, 32'h0000_AB00, 4'b0010);
    access(16'h4000, 32'h0, 4'b0);
    check("cmp_strb", last_rd[0], 32'hFFFF_ABFF);

    // Unmapped offset still responds with zero
    access(16'h1234, 32'hDEAD_BEEF, 4'b1111);
    access(16'h1234, 32'h0, 4'b0);
    check("unmapped", last_rd[0], 32'h0);

    // Timer match on mtimecmp = 20
    access(16'h4004, 32'h0, 4'b1111);
    access(16'h4000, 32'd20, 4'b1111);
    for (int k = 0; k < 100 && !m_timer[0]; k++) step();
    check("timer_rise", ti[0], 1'b1);
    access(16'h4000, 32'hFFFF_FFFF, 4'b1111);
    idle(2);
    check("timer_fall", ti[0], 1'b0);

    // Software interrupt
    access(16'h0000, 32'hFFFF_FFFF, 4'b1111);
    access(16'h0000, 32'h0, 4'b0);
    check("msip_rd", last_rd[0], 32'h1);
    check("soft_set", si[0], 1'b1);
    access(16'h0000, 32'h0, 4'b1111);
    idle(1);
    check("soft_clr", si[0], 1'b0);

    // mtime wrap, write coinciding with tick on the divider-1 instance
    access(16'hBFFC, 32'hFFFF_FFFF, 4'b1111);
    access(16'hBFF8, 32'hFFFF_FFFF, 4'b1111);
    access(16'hBFFC, 32'h0, 4'b0);
    check("wrap_hi", last_rd[1], 32'h0);
    access(16'h4004, 32'h0, 4'b1111);
    access(16'h4000, 32'h0, 4'b1111);
    idle(2);
    check("cmp0_timer", ti[1], 1'b1);

    // Back-to-back requests with valid held high
    valid  = 1'b1;
    addr   = 32'h0000_0000;
    wstrb  = 4'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ready[0]) pulses++;
    end
    valid = 1'b0;
    step();
    check("pulses", pulses, 32'd3);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      off   = pick_off($urandom_range(0, 6));
      valid = ($urandom_range(0, 2) != 0);
      addr  = {16'($urandom()), off};
      wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom()) : 4'b0;
      wdata = (off == 16'h4004 || off == 16'hBFFC) ? 32'($urandom_range(0, 1)) : $urandom();
      step();
    end
    idle(2);

    // Reset asserted during an acceptance cycle
    valid = 1'b1;
    addr  = 32'h0000_0000;
    wstrb = 4'b0;
    #3 rst = 1'b0;
    #1 check_cleared("rst_acc");
    @(posedge clk);
    #1;
    check("rst_acc_noready0", ready[0], 1'b0);
    check("rst_acc_noready1", ready[1], 1'b0);
    valid = 1'b0;
    model_reset();
    rst = 1'b1;

    // Reset while a response is pending
    valid = 1'b1;
    addr  = 32'h0000_4000;
    step();
    valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_cleared("rst_pend");
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;

    access(16'h4004, 32'h0, 4'b0);
    check("post_rst_rd", last_rd[0], 32'hFFFF_FFFF);
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
